// File: rtl/seq_control_unit_if.sv
// Interface between the instruction-cycle sequencer and the datapath.
// The datapath side (master) drives the instruction register and status
// flags. The sequencer side (slave) returns the timing, decode and control flags.
interface seq_control_unit_if;
  logic [15:0] ir;
  logic        start;
  logic        fgi;
  logic        fgo;
  logic [7:0]  T;
  logic [7:0]  D;
  logic        I;
  logic [15:0] B;
  logic        R;
  logic        S;
  logic        IEN;

  modport master (
    output ir, start, fgi, fgo,
    input  T, D, I, B, R, S, IEN
  );

  modport slave (
    input  ir, start, fgi, fgo,
    output T, D, I, B, R, S, IEN
  );
endinterface

// File: rtl/seq_control_unit.sv
// Instruction-cycle sequencer for the basic computer.
// It owns the sequence counter, the run flag (held as a two-state FSM), the
// interrupt-cycle flag and the interrupt enable. It produces the one-hot
// timing and the registered opcode decode that steer the datapath through
// fetch, decode, indirect, execute and interrupt phases.
module seq_control_unit #(
  parameter bit AUTO_START = 1'b0,
  parameter bit IEN_RESET  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  seq_control_unit_if.slave  bus
);

  typedef enum logic {
    HALTED  = 1'b0,
    RUNNING = 1'b1
  } run_state_e;

  localparam run_state_e RUN_RESET = AUTO_START ? RUNNING : HALTED;

  run_state_e  run_q, run_d;
  logic [2:0]  sc_q, sc_d;
  logic        r_q, r_d;
  logic        ien_q, ien_d;
  logic [7:0]  dec_q, dec_d;
  logic        ind_q, ind_d;

  logic [7:0]  t;
  logic        running;
  logic        sc_clr;
  logic        reg_ref;
  logic        io_ref;
  logic        int_detect;

  assign running = (run_q == RUNNING);

  // Timing decode comes only from registered SC and S, so T never sees an input.
  always_comb begin
    t = 8'h00;
    if (running) begin
      t = 8'b0000_0001 << sc_q;
    end
  end

  // Terms that end an instruction, select reg-ref/IO work and spot interrupts.
  always_comb begin
    sc_clr = (dec_q[0] & t[5]) | (dec_q[1] & t[5]) | (dec_q[2] & t[5]) |
             (dec_q[3] & t[4]) | (dec_q[4] & t[4]) | (dec_q[5] & t[5]) |
             (dec_q[6] & t[6]) | (dec_q[7] & t[3]) | (r_q & t[2]);
    reg_ref    = dec_q[7] & ~ind_q & t[3];
    io_ref     = dec_q[7] &  ind_q & t[3];
    int_detect = running & ~r_q & ~(t[0] | t[1] | t[2]) & ien_q &
                 (bus.fgi | bus.fgo);
  end

  // Next-state logic for the run FSM, sequence counter, decode and flags.
  always_comb begin
    run_d = run_q;
    sc_d  = sc_q;
    r_d   = r_q;
    ien_d = ien_q;
    dec_d = dec_q;
    ind_d = ind_q;
    case (run_q)
      HALTED: begin
        if (bus.start) begin
          run_d = RUNNING;
          sc_d  = 3'd0;
        end
      end
      RUNNING: begin
        sc_d = sc_clr ? 3'd0 : sc_q + 3'd1;
        // The fetch decode happens only on the normal path, never in the interrupt cycle.
        if (~r_q & t[2]) begin
          dec_d = 8'b0000_0001 << bus.ir[14:12];
          ind_d = bus.ir[15];
        end
        if (reg_ref & bus.ir[0]) begin
          run_d = HALTED;
          sc_d  = 3'd0;
        end
        if (io_ref & bus.ir[7]) begin
          ien_d = 1'b1;
        end
        if (io_ref & bus.ir[6]) begin
          ien_d = 1'b0;
        end
        // Detection uses the pre-edge IEN, so an ION at T3 cannot raise R in that cycle.
        if (int_detect) begin
          r_d = 1'b1;
        end
        if (r_q & t[2]) begin
          r_d   = 1'b0;
          ien_d = 1'b0;
        end
      end
      default: begin
        run_d = HALTED;
      end
    endcase
  end

  // State registers; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= RUN_RESET;
      sc_q  <= 3'd0;
      r_q   <= 1'b0;
      ien_q <= IEN_RESET;
      dec_q <= 8'h00;
      ind_q <= 1'b0;
    end else begin
      run_q <= run_d;
      sc_q  <= sc_d;
      r_q   <= r_d;
      ien_q <= ien_d;
      dec_q <= dec_d;
      ind_q <= ind_d;
    end
  end

  assign bus.T   = t;
  assign bus.D   = dec_q;
  assign bus.I   = ind_q;
  assign bus.B   = bus.ir;
  assign bus.R   = r_q;
  assign bus.S   = running;
  assign bus.IEN = ien_q;

endmodule
